// File: rtl/bist_sequencer.sv
// BIST session sequencer: seeds the LFSR, clocks N patterns through the circuit under test,
// flushes the MISR, compares the signature with the golden value and keeps pass/fail results.
module bist_sequencer (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] pattern_count_i,
    input  logic [3:0] golden_sig_i,
    input  logic [3:0] misr_in_i,
    output logic       cut_testmode_o,
    output logic       lfsr_load_o,
    output logic       lfsr_en_o,
    output logic       misr_clear_o,
    output logic       misr_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       aborted_o,
    output logic       pass_o,
    output logic       fault_detected_o,
    output logic [7:0] pattern_idx_o,
    output logic [3:0] fail_count_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_FLUSH   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] n_q, n_d;
    logic [3:0] golden_q, golden_d;
    logic [7:0] idx_q, idx_d;
    logic       pass_q, pass_d;
    logic       fault_q, fault_d;
    logic [3:0] fail_q, fail_d;
    logic       aborted_q, aborted_d;
    logic       busy;

    assign busy = (state_q == S_INIT) || (state_q == S_RUN) ||
                  (state_q == S_FLUSH) || (state_q == S_COMPARE);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            n_q       <= 8'd0;
            golden_q  <= 4'd0;
            idx_q     <= 8'd0;
            pass_q    <= 1'b0;
            fault_q   <= 1'b0;
            fail_q    <= 4'd0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            golden_q  <= golden_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            fault_q   <= fault_d;
            fail_q    <= fail_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        golden_d  = golden_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        fault_d   = fault_q;
        fail_d    = fail_q;
        aborted_d = 1'b0;
        // Abort wins over every busy-state transition; pattern_idx is left where it stopped.
        if (busy && abort_i) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            pass_d    = 1'b0;
            fault_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_d  = S_INIT;
                        n_d      = pattern_count_i;
                        golden_d = golden_sig_i;
                        pass_d   = 1'b0;
                        fault_d  = 1'b0;
                    end
                end
                S_INIT: begin
                    idx_d   = 8'd0;
                    state_d = (n_q != 8'd0) ? S_RUN : S_COMPARE;
                end
                S_RUN: begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == n_q - 8'd1) begin
                        state_d = S_FLUSH;
                    end
                end
                S_FLUSH: state_d = S_COMPARE;
                S_COMPARE: begin
                    state_d = S_DONE;
                    if (misr_in_i == golden_q) begin
                        pass_d  = 1'b1;
                        fault_d = 1'b0;
                    end else begin
                        pass_d  = 1'b0;
                        fault_d = 1'b1;
                        if (fail_q != 4'hF) begin
                            fail_d = fail_q + 4'd1;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy_o           = busy;
    assign cut_testmode_o   = busy;
    assign lfsr_load_o      = (state_q == S_INIT);
    assign misr_clear_o     = (state_q == S_INIT);
    assign lfsr_en_o        = (state_q == S_RUN);
    assign misr_en_o        = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done_o           = (state_q == S_DONE);
    assign aborted_o        = aborted_q;
    assign pass_o           = pass_q;
    assign fault_detected_o = fault_q;
    assign pattern_idx_o    = idx_q;
    assign fail_count_o     = fail_q;
    assign state_o          = state_q;

endmodule
